// File: rtl/vending_machine.sv
// Soda vending controller: accumulates nickel/dime/quarter credit toward a 20c
// price, dispensing one soda and refunding the excess in nickels.
module vending_machine (
    input  logic       clk,
    input  logic       rst,
    input  logic       nick_i,
    input  logic       dime_i,
    input  logic       quar_i,
    output logic       soda_o,
    output logic [2:0] chan_o
);

    localparam logic [1:0] S0  = 2'd0;
    localparam logic [1:0] S5  = 2'd1;
    localparam logic [1:0] S10 = 2'd2;
    localparam logic [1:0] S15 = 2'd3;
    localparam logic [3:0] PRICE = 4'd4;

    // Coin value in nickels for one sampled edge; simultaneous coins are summed.
    function automatic logic [3:0] coin_value(input logic n, input logic d, input logic q);
        logic [3:0] v;
        v = 4'd0;
        if (n) v = v + 4'd1;
        if (d) v = v + 4'd2;
        if (q) v = v + 4'd5;
        return v;
    endfunction

    logic [1:0] r_state;
    logic [3:0] w_credit;
    logic [3:0] w_total;
    logic [3:0] w_excess;
    logic [1:0] w_next_state;
    logic       w_soda;
    logic [2:0] w_chan;

    // Credit held in the current state, in nickels.
    always_comb begin
        w_credit = 4'd0;
        case (r_state)
            S0:      w_credit = 4'd0;
            S5:      w_credit = 4'd1;
            S10:     w_credit = 4'd2;
            S15:     w_credit = 4'd3;
            default: w_credit = 4'd0;
        endcase
    end

    // Purchase decision; with no coin the total stays below the price so credit holds.
    always_comb begin
        w_total      = w_credit + coin_value(nick_i, dime_i, quar_i);
        w_excess     = w_total - PRICE;
        w_next_state = S0;
        w_soda       = 1'b0;
        w_chan       = 3'd0;
        if (w_total >= PRICE) begin
            w_next_state = S0;
            w_soda       = 1'b1;
            w_chan       = w_excess[2:0];
        end else begin
            w_next_state = w_total[1:0];
            w_soda       = 1'b0;
            w_chan       = 3'd0;
        end
    end

    // State and registered outputs; reset discards credit without refund.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
            soda_o  <= 1'b0;
            chan_o  <= 3'd0;
        end else begin
            r_state <= w_next_state;
            soda_o  <= w_soda;
            chan_o  <= w_chan;
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed plan plus random coins,
// compared against a cents-based purchase model.
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic       nick_i;
    logic       dime_i;
    logic       quar_i;
    logic       soda_o;
    logic [2:0] chan_o;

    int checks;
    int failures;
    int credit_cents;
    logic       exp_soda;
    logic [2:0] exp_chan;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .nick_i (nick_i),
        .dime_i (dime_i),
        .quar_i (quar_i),
        .soda_o (soda_o),
        .chan_o (chan_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of coins, update the model at the edge, check just after it.
    task automatic step(input logic n, input logic d, input logic q, input string tag);
        int total;
        @(negedge clk);
        nick_i = n;
        dime_i = d;
        quar_i = q;
        @(posedge clk);
        total = credit_cents + (n ? 5 : 0) + (d ? 10 : 0) + (q ? 25 : 0);
        if (total >= 20) begin
            exp_soda     = 1'b1;
            exp_chan     = 3'((total - 20) / 5);
            credit_cents = 0;
        end else begin
            exp_soda     = 1'b0;
            exp_chan     = 3'd0;
            credit_cents = total;
        end
        #1;
        check({tag, "_soda"}, {7'd0, soda_o}, {7'd0, exp_soda});
        check({tag, "_chan"}, {5'd0, chan_o}, {5'd0, exp_chan});
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic mid_reset(input string tag);
        #2;
        rst    = 1'b0;
        nick_i = 1'b0;
        dime_i = 1'b0;
        quar_i = 1'b0;
        #1;
        credit_cents = 0;
        check({tag, "_soda"}, {7'd0, soda_o}, 8'd0);
        check({tag, "_chan"}, {5'd0, chan_o}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        credit_cents = 0;
        rst    = 1'b0;
        nick_i = 1'b0;
        dime_i = 1'b0;
        quar_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_soda", {7'd0, soda_o}, 8'd0);
        check("reset_chan", {5'd0, chan_o}, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, "nickels");
            step(1'b0, 1'b0, 1'b0, "nickels_idle");
        end
        step(1'b0, 1'b1, 1'b0, "dime1");
        step(1'b0, 1'b1, 1'b0, "dime2");
        step(1'b0, 1'b0, 1'b1, "quar1");
        step(1'b0, 1'b0, 1'b1, "quar2");
        step(1'b0, 1'b0, 0, "idle");
        step(1'b1, 1'b0, 1'b0, "nnd_n1");
        step(1'b1, 1'b0, 1'b0, "nnd_n2");
        step(1'b0, 1'b1, 1'b0, "nnd_d");
        step(1'b1, 1'b0, 1'b0, "ndq_n");
        step(1'b0, 1'b1, 1'b0, "ndq_d");
        step(1'b0, 1'b0, 1'b1, "ndq_q");
        step(1'b1, 1'b0, 1'b0, "s15_n");
        step(1'b0, 1'b1, 1'b0, "s15_d");
        step(1'b1, 1'b1, 1'b1, "s15_all");
        step(1'b1, 1'b1, 1'b1, "s0_all");

        step(1'b1, 1'b0, 1'b0, "rst_pre_n");
        step(1'b0, 1'b0, 1'b1, "rst_pre_q");
        mid_reset("rst_during_soda");
        step(1'b0, 1'b1, 1'b0, "rst_dime");
        mid_reset("rst_after_dime");
        step(1'b0, 1'b1, 1'b0, "post_rst_dime1");
        step(1'b0, 1'b1, 1'b0, "post_rst_dime2");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), "random");
            if ($urandom_range(0, 49) == 0) begin
                mid_reset("random_rst");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
